// File: rtl/apb2axi_fifo_mq.sv
// First-word-fall-through circular FIFO between the APB request decoder and the AXI issue engines.
// Optional zero-latency empty bypass enabled by defining APB2AXI_FIFO_BYPASS_EN.
module apb2axi_fifo_mq #(
    parameter int ENTRY_WIDTH = 64,
    parameter int DEPTH       = 4,
    parameter int AFULL_LVL   = DEPTH - 1,
    parameter int AEMPTY_LVL  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [ENTRY_WIDTH-1:0]       push_data,
    output logic                         pop_valid,
    input  logic                         pop_ready,
    output logic [ENTRY_WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         overflow
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] AF_LVL = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AE_LVL = CW'(AEMPTY_LVL);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("apb2axi_fifo_mq: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [ENTRY_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   r_overflow;

    logic w_empty;
    logic w_full;
    logic w_byp_take;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]) && (r_wr_ptr[IW] != r_rd_ptr[IW]);

`ifdef APB2AXI_FIFO_BYPASS_EN
    logic w_byp_path;
    // While empty the producer drives the consumer directly; flush and reset suppress it.
    assign w_byp_path = w_empty && !flush && !reset;
    assign w_byp_take = w_byp_path && push_valid && pop_ready;
    assign pop_valid  = w_byp_path ? push_valid : !w_empty;
    assign pop_data   = w_byp_path ? push_data : r_mem[r_rd_ptr[IW-1:0]];
`else
    assign w_byp_take = 1'b0;
    assign pop_valid  = !w_empty;
    assign pop_data   = r_mem[r_rd_ptr[IW-1:0]];
`endif

    assign push_ready   = !w_full;
    assign w_push       = push_valid && !w_full && !w_byp_take && !flush;
    assign w_pop        = !w_empty && pop_ready && !flush;
    assign count        = r_count;
    assign almost_full  = (r_count >= AF_LVL);
    assign almost_empty = (r_count <= AE_LVL);
    assign overflow     = r_overflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (push_valid && w_full)
                r_overflow <= 1'b1;
        end
    end

    // Payload storage carries no reset; only pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[IW-1:0]] <= push_data;
    end

endmodule

// File: tb/tb_apb2axi_fifo_mq.sv
// Randomised and directed bench for apb2axi_fifo_mq (DEPTH=4, ENTRY_WIDTH=8) against a queue model.
// Expectations follow APB2AXI_FIFO_BYPASS_EN when the bench is built with it.
module tb_apb2axi_fifo_mq;
    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         push_valid;
    logic         push_ready;
    logic [W-1:0] push_data;
    logic         pop_valid;
    logic         pop_ready;
    logic [W-1:0] pop_data;
    logic [2:0]   count;
    logic         almost_full;
    logic         almost_empty;
    logic         overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] q[$];
    logic         m_ovf;

`ifdef APB2AXI_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    apb2axi_fifo_mq #(.ENTRY_WIDTH(W), .DEPTH(D), .AFULL_LVL(D-1), .AEMPTY_LVL(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
        .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model view of the outputs given the current occupancy and current inputs.
    task automatic check_all();
        logic byp;
        logic exp_pv;
        byp    = BYP && (q.size() == 0) && !flush && !reset;
        exp_pv = byp ? push_valid : (q.size() != 0);
        chk_eq("push_ready", push_ready, q.size() < D);
        chk_eq("pop_valid", pop_valid, exp_pv);
        if (exp_pv)
            chk_eq("pop_data", pop_data, byp ? push_data : q[0]);
        chk_eq("count", count, q.size());
        chk_eq("almost_full", almost_full, q.size() >= D-1);
        chk_eq("almost_empty", almost_empty, q.size() <= 1);
        chk_eq("overflow", overflow, m_ovf);
    endtask

    // Apply the FIFO's rules to the queue using the inputs present at this edge.
    task automatic model_edge();
        int  n;
        logic do_pop, do_push;
        n = q.size();
        if (reset) begin
            q.delete();
            m_ovf = 1'b0;
        end else if (flush) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            if (push_valid && n == D) m_ovf = 1'b1;
            if (BYP && n == 0 && push_valid && pop_ready) begin
                do_pop  = 1'b0;
                do_push = 1'b0;
            end else begin
                do_pop  = (n > 0) && pop_ready;
                do_push = push_valid && (n < D);
            end
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(push_data);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic pv, input logic [W-1:0] pd, input logic pr, input logic fl);
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        flush      = fl;
    endtask

    task automatic random_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0);
            #1 check_all();
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        m_ovf = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_eq("rst_push_ready", push_ready, 1);
        chk_eq("rst_pop_valid", pop_valid, 0);
        chk_eq("rst_count", count, 0);
        chk_eq("rst_aempty", almost_empty, 1);
        chk_eq("rst_overflow", overflow, 0);
        @(negedge clk);

        // Fill to full, then one rejected push.
        for (int i = 0; i < D; i++) begin
            drive(1'b1, W'((i + 1) * 8'h11), 1'b0, 1'b0);
            step();
            chk_eq("fill_count", count, i + 1);
            chk_eq("fill_afull", almost_full, (i + 1) >= 3);
        end
        chk_eq("full_push_ready", push_ready, 0);
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        step();
        chk_eq("ovf_set", overflow, 1);
        chk_eq("ovf_count", count, 4);

        for (int i = 0; i < D; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            #1 chk_eq("drain_data", pop_data, W'((i + 1) * 8'h11));
            step();
        end
        chk_eq("drain_count", count, 0);
        chk_eq("drain_ovf_sticky", overflow, 1);

        // Streaming through pointer wrap.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, W'(i), 1'b1, 1'b0);
            #1;
            if (i > 0 && !BYP) chk_eq("stream_data", pop_data, W'(i - 1));
            step();
            chk_eq("stream_count", count, BYP ? 0 : 1);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();

        // Full FIFO, simultaneous push and pop: pop only.
        for (int i = 0; i < D; i++) begin
            drive(1'b1, W'(8'hA0 + i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'hB0, 1'b1, 1'b0);
        step();
        chk_eq("fullpp_count", count, 3);
        drive(1'b1, 8'hB0, 1'b0, 1'b0);
        step();
        chk_eq("fullpp_next", count, 4);

        // Flush with three entries and a concurrent push/pop.
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        drive(1'b1, 8'hAA, 1'b1, 1'b1);
        step();
        flush = 1'b0;
        push_valid = 1'b0;
        #1;
        chk_eq("flush_count", count, 0);
        chk_eq("flush_pop_valid", pop_valid, 0);
        chk_eq("flush_ovf", overflow, 0);
        @(negedge clk);

        // Empty push with pop_ready: bypass or one-cycle latency.
        drive(1'b1, 8'h5A, 1'b1, 1'b0);
        #1 chk_eq("byp_pop_valid", pop_valid, BYP);
        if (BYP) chk_eq("byp_pop_data", pop_data, 8'h5A);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk_eq("byp_count", count, BYP ? 0 : 1);
        chk_eq("lat_pop_valid", pop_valid, !BYP);
        if (!BYP) chk_eq("lat_pop_data", pop_data, 8'h5A);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();

        random_run(400);

        // Asynchronous reset mid-operation.
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        step();
        step();
        #2 reset = 1'b1;
        #1;
        q.delete();
        m_ovf = 1'b0;
        chk_eq("mid_rst_count", count, 0);
        chk_eq("mid_rst_push_ready", push_ready, 1);
        chk_eq("mid_rst_pop_valid", pop_valid, 0);
        chk_eq("mid_rst_aempty", almost_empty, 1);
        chk_eq("mid_rst_afull", almost_full, 0);
        chk_eq("mid_rst_ovf", overflow, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 8'hC3, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'h3C, 1'b1, 1'b0);
        #1 chk_eq("post_rst_first", pop_data, 8'hC3);
        step();

        random_run(600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
